// File: rtl/spbram_arbiter.sv
// spbram_arbiter
//
// Shares one single-port block RAM (registered read, one write enable) between
// two requesters: port A (instruction fetch) and port B (load/store). Only one
// access is in flight at a time. When both ports ask at once, the port that was
// not granted last wins, so sustained contention alternates A,B,A,B.
//
// Timeline of one access granted in cycle N:
//   N    : gnt pulse to the winner (requester fields still held stable)
//   N+1  : bram_addr/bram_we/bram_din carry the access; RAM acts at end of N+1
//   N+2  : write -> done pulse; read -> bram_dout valid and captured at end of N+2
//   N+3  : read  -> done pulse with rdata updated
// A new grant may be issued in the same cycle as the previous done.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request, held until a_gnt
//   a_gnt, a_done              port A accept / completion pulses
//   a_rdata                    port A read data, updated on a read completion
//   b_*                        same for port B
//   bram_we/addr/din           RAM control, registered
//   bram_dout                  RAM read data, valid one cycle after the address
module spbram_arbiter #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        a_req,
  input  logic                        a_we,
  input  logic [ADDRESS_BITWIDTH-1:0] a_addr,
  input  logic [DATA_BITWIDTH-1:0]    a_wdata,
  output logic                        a_gnt,
  output logic                        a_done,
  output logic [DATA_BITWIDTH-1:0]    a_rdata,

  input  logic                        b_req,
  input  logic                        b_we,
  input  logic [ADDRESS_BITWIDTH-1:0] b_addr,
  input  logic [DATA_BITWIDTH-1:0]    b_wdata,
  output logic                        b_gnt,
  output logic                        b_done,
  output logic [DATA_BITWIDTH-1:0]    b_rdata,

  output logic                        bram_we,
  output logic [ADDRESS_BITWIDTH-1:0] bram_addr,
  output logic [DATA_BITWIDTH-1:0]    bram_din,
  input  logic [DATA_BITWIDTH-1:0]    bram_dout
);

  // GRANT is the cycle in which gnt is high; the requester fields are still
  // stable there, so the RAM control registers are loaded straight from them.
  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  state_t state;
  port_t  owner;
  port_t  last_grant;

  logic any_req;
  logic pick_b;
  logic can_grant;

  // Round-robin choice: on a tie the port that did not win last time goes.
  // A new grant is allowed from IDLE and on the edge that raises done, which is
  // the end of ACCESS for a write (bram_we is still high there) or end of RESP.
  always_comb begin
    any_req   = a_req | b_req;
    pick_b    = 1'b0;
    can_grant = 1'b0;
    if (a_req && b_req) begin
      pick_b = (last_grant == PORT_A);
    end else begin
      pick_b = b_req;
    end
    case (state)
      IDLE:    can_grant = 1'b1;
      RESP:    can_grant = 1'b1;
      ACCESS:  can_grant = bram_we;
      default: can_grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= PORT_A;
      last_grant <= PORT_B;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
    end else begin
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;

      case (state)
        IDLE: begin
          state <= IDLE;
        end

        GRANT: begin
          if (owner == PORT_A) begin
            bram_we   <= a_we;
            bram_addr <= a_addr;
            bram_din  <= a_wdata;
          end else begin
            bram_we   <= b_we;
            bram_addr <= b_addr;
            bram_din  <= b_wdata;
          end
          state <= ACCESS;
        end

        // bram_we still holds the access type here; a write is finished once
        // the RAM edge at the end of this cycle has happened.
        ACCESS: begin
          bram_we <= 1'b0;
          if (bram_we) begin
            if (owner == PORT_A) begin
              a_done <= 1'b1;
            end else begin
              b_done <= 1'b1;
            end
            state <= IDLE;
          end else begin
            state <= RESP;
          end
        end

        RESP: begin
          if (owner == PORT_A) begin
            a_rdata <= bram_dout;
            a_done  <= 1'b1;
          end else begin
            b_rdata <= bram_dout;
            b_done  <= 1'b1;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Overrides the IDLE fall-back above when a request is waiting.
      if (can_grant && any_req) begin
        state <= GRANT;
        if (pick_b) begin
          owner      <= PORT_B;
          last_grant <= PORT_B;
          b_gnt      <= 1'b1;
        end else begin
          owner      <= PORT_A;
          last_grant <= PORT_A;
          a_gnt      <= 1'b1;
        end
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(a_gnt && b_gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(a_done && b_done));

endmodule
